// File: rtl/mod_n_pkg.sv
// Shared types and defaults for the modulo-N counter family.
package mod_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MOD_DEF    = 5;
  localparam int DIGITS_DEF = 2;

  function automatic int digit_width(input int m);
    return $clog2(m);
  endfunction

endpackage

// File: rtl/mod_n_countdown_timer_if.sv
// Control/status bundle for the countdown timer; master drives commands, slave is the timer.
interface mod_n_countdown_timer_if
  import mod_n_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int DW     = digit_width(MOD_DEF)
);

  // No valid/ready pairing: load and start are level-sampled every edge and
  // only take effect in IDLE; done and load_err are single-cycle pulses.
  logic                 load;
  logic [DIGITS*DW-1:0] load_val;
  logic                 start;
  logic                 pause;
  logic [DIGITS*DW-1:0] count;
  logic                 busy;
  logic                 done;
  logic                 load_err;
  state_t               state;

  modport master (
    output load, load_val, start, pause,
    input  count, busy, done, load_err, state
  );

  modport slave (
    input  load, load_val, start, pause,
    output count, busy, done, load_err, state
  );

endinterface

// File: rtl/mod_down_digit.sv
// One base-MOD down-counting digit with parallel load and borrow output.
module mod_down_digit #(
  parameter int MOD = 5,
  parameter int DW  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [DW-1:0] ld_val,
  input  logic          dec,
  output logic [DW-1:0] q,
  output logic          borrow_out
);

  assign borrow_out = dec & (q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (dec) begin
      q <= (q == '0) ? DW'(MOD - 1) : q - 1'b1;
    end
  end

endmodule

// File: rtl/mod_n_countdown_timer.sv
// Multi-digit base-MOD countdown timer: load, start, count down with pause, pulse done.
module mod_n_countdown_timer
  import mod_n_pkg::*;
#(
  parameter int MOD    = MOD_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  mod_n_countdown_timer_if.slave  bus
);

  localparam int DW = digit_width(MOD);
  localparam int CW = DIGITS * DW;

  state_t          state, state_nx;
  logic            fields_ok;
  logic            ld_en;
  logic            cnt_zero;
  logic            cnt_one;
  logic            load_err_q;
  logic [CW-1:0]   q_all;
  logic [DIGITS-1:0] dec;
  logic [DIGITS-1:0] borrow;

  always_comb begin
    fields_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (32'(bus.load_val[i*DW +: DW]) >= 32'(MOD)) fields_ok = 1'b0;
    end
  end

  assign ld_en    = (state == ST_IDLE) && bus.load && fields_ok;
  assign cnt_zero = (q_all == '0);
  assign cnt_one  = (q_all == CW'(1));
  assign dec[0]   = (state == ST_RUN) && !bus.pause;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    mod_down_digit #(.MOD(MOD), .DW(DW)) u_dig (
      .clk        (clk),
      .rst        (rst),
      .ld         (ld_en),
      .ld_val     (bus.load_val[i*DW +: DW]),
      .dec        (dec[i]),
      .q          (q_all[i*DW +: DW]),
      .borrow_out (borrow[i])
    );
    if (i > 0) begin : g_chain
      assign dec[i] = borrow[i-1];
    end
  end

  // The FSM leaves RUN at count==1, so the top digit never borrows.
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !borrow[DIGITS-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      load_err_q <= 1'b0;
    end else begin
      state      <= state_nx;
      load_err_q <= (state == ST_IDLE) && bus.load && !fields_ok;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (!bus.load && bus.start) state_nx = cnt_zero ? ST_DONE : ST_RUN;
      ST_RUN:  if (!bus.pause && cnt_one)  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.count    = q_all;
  assign bus.busy     = (state == ST_RUN);
  assign bus.done     = (state == ST_DONE);
  assign bus.load_err = load_err_q;
  assign bus.state    = state;

endmodule

// File: tb/tb_mod_n_countdown_timer.sv
// Bench for mod_n_countdown_timer: directed scenarios plus random traffic against a value-level model.
module tb_mod_n_countdown_timer;

  localparam int MOD    = 5;
  localparam int DIGITS = 2;
  localparam int DW     = 3;
  localparam int LW     = DIGITS * DW;
  localparam int W      = LW + 3;

  logic clk;
  logic rst;

  mod_n_countdown_timer_if #(.DIGITS(DIGITS), .DW(DW)) bus ();

  mod_n_countdown_timer #(.MOD(MOD), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // reference model: the count is one integer, phases are idle/counting/finished
  int m_val   = 0;
  int m_phase = 0;   // 0 idle, 1 counting, 2 finished
  bit m_err   = 0;

  function automatic int field_of(input logic [LW-1:0] v, input int i);
    return int'((v >> (i * DW)) & LW'((1 << DW) - 1));
  endfunction

  function automatic bit fields_valid(input logic [LW-1:0] v);
    for (int i = 0; i < DIGITS; i++) if (field_of(v, i) >= MOD) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int value_of(input logic [LW-1:0] v);
    int acc = 0;
    int wt  = 1;
    for (int i = 0; i < DIGITS; i++) begin
      acc += field_of(v, i) * wt;
      wt  *= MOD;
    end
    return acc;
  endfunction

  function automatic logic [LW-1:0] to_packed(input int v);
    logic [LW-1:0] p = '0;
    int rem = v;
    for (int i = 0; i < DIGITS; i++) begin
      p   |= LW'(rem % MOD) << (i * DW);
      rem /= MOD;
    end
    return p;
  endfunction

  function automatic logic [LW-1:0] pk(input int d1, input int d0);
    return LW'((d1 << DW) | d0);
  endfunction

  task automatic model_edge(input bit r, input bit l, input logic [LW-1:0] lv,
                            input bit s, input bit p);
    m_err = 1'b0;
    if (r) begin
      m_val   = 0;
      m_phase = 0;
    end else begin
      case (m_phase)
        0: begin
          if (l) begin
            if (fields_valid(lv)) m_val = value_of(lv);
            else m_err = 1'b1;
          end else if (s) begin
            m_phase = (m_val == 0) ? 2 : 1;
          end
        end
        1: if (!p) begin
          m_val = m_val - 1;
          if (m_val == 0) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
    exp_q.push_back({to_packed(m_val), m_phase == 1, m_phase == 2, m_err});
  endtask

  // driver: apply inputs, clock once, update model, compare #1 after the edge
  task automatic step(input bit r, input bit l, input logic [LW-1:0] lv,
                      input bit s, input bit p);
    logic [W-1:0] e;
    rst          = r;
    bus.load     = l;
    bus.load_val = lv;
    bus.start    = s;
    bus.pause    = p;
    @(posedge clk);
    model_edge(r, l, lv, s, p);
    #1;
    e = exp_q.pop_front();
    check("count",    32'(bus.count),    32'(e[W-1:3]));
    check("busy",     32'(bus.busy),     32'(e[2]));
    check("done",     32'(bus.done),     32'(e[1]));
    check("load_err", 32'(bus.load_err), 32'(e[0]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;

    // reset
    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    check("reset_count", 32'(bus.count), 32'(0));

    // basic countdown from 12
    step(0, 1, pk(1, 2), 0, 0);
    step(0, 0, '0, 1, 0);
    idle(9);

    // borrow / wrap from 40
    step(0, 1, pk(4, 0), 0, 0);
    step(0, 0, '0, 1, 0);
    idle(6);
    check("wrap_count", 32'(bus.count), 32'(pk(2, 4)));
    idle(16);

    // pause after the first decrement from 03
    step(0, 1, pk(0, 3), 0, 0);
    step(0, 0, '0, 1, 0);
    idle(1);
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 1);
    idle(5);

    // zero-length countdown
    step(0, 0, '0, 1, 0);
    idle(2);

    // invalid load, then load+start together
    step(0, 1, pk(1, 5), 0, 0);
    idle(1);
    step(0, 1, pk(1, 3), 1, 0);
    step(0, 0, '0, 1, 0);
    step(0, 1, pk(4, 4), 1, 0);
    step(0, 1, pk(1, 7), 0, 0);
    idle(10);

    // reset mid-run at 41
    step(0, 1, pk(4, 4), 0, 0);
    step(0, 0, '0, 1, 0);
    idle(3);
    check("pre_rst_count", 32'(bus.count), 32'(pk(4, 1)));
    step(1, 0, '0, 0, 0);
    idle(3);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [LW-1:0] lv;
      lv = LW'($urandom_range(0, (1 << LW) - 1));
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 12,
           lv,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 25);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_n_countdown_timer.md
Name: mod_n_countdown_timer

Overview:
- Multi-digit countdown timer built from cascaded modulo-MOD down-counting digits. It is the decrementing counterpart of the team's mod-N up counters.
- Software or a host FSM loads a base-MOD value and pulses start. The block counts down once per enabled clock, then reports completion with a single-cycle done pulse.
- Used as a programmable delay/timeout source alongside the existing counter blocks.

Parameters:
- MOD, 5, modulus of each digit; digit values 0..MOD-1; MOD >= 2.
- DIGITS, 2, number of cascaded digits; digit 0 is least significant.
- DW, $clog2(MOD), bits per digit (3 for MOD=5).

Ports:
- clk  in  1  clock; all logic is posedge clk.
- rst  in  1  reset, synchronous, active-high.
- load  in  1  load request; honoured only in IDLE.
- load_val  in  DIGITS*DW  load value; digit i is in bits [i*DW +: DW].
- start  in  1  start countdown; honoured only in IDLE.
- pause  in  1  holds count while in RUN.
- count  out  DIGITS*DW  current digit values, same packing as load_val.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle completion pulse.
- load_err  out  1  one-cycle pulse: load rejected because a digit field is >= MOD.

Behaviour:
- Reset, which overrides everything including mid-run: count=0, busy=0, done=0, load_err=0, state=IDLE.
- States are IDLE, RUN and DONE. Outputs are registered.
  - busy=1 only in RUN.
  - done=1 only in DONE.
- IDLE + load with all fields < MOD: count <= load_val on the next edge. load_err stays 0.
- IDLE + load with any field >= MOD: count unchanged; load_err=1 for exactly one cycle.
- IDLE + load + start in the same cycle: load is processed; start is ignored.
- IDLE + start, no load, count != 0: RUN on the next edge, count unchanged.
- IDLE + start, count == 0: DONE on the next edge (zero-length countdown).
- RUN, pause=0: count decrements by 1 in base-MOD.
  - Digit 0 always decrements.
  - Digit i>0 decrements only when every lower digit is 0 (borrow).
  - A digit at 0 that decrements wraps to MOD-1.
- RUN, pause=1: count holds; state stays RUN; busy stays 1.
- RUN, decrementing from count==1 (digit 0 = 1, all higher digits 0): count becomes 0 and the next state is DONE.
- DONE: count holds 0; done=1 for one cycle; then IDLE unconditionally.
- In RUN and DONE, load and start are ignored (no load_err).
- Latency with start sampled at edge E and initial value N>0, no pause:
  - busy=1 from E+1 through E+N.
  - count=0 and done=1 after edge E+N+1.
  - busy=0 in that same cycle.
- Width rules:
  - Each digit is strictly DW bits and never holds a value >= MOD.
  - No arithmetic across the full vector; borrow propagates digit to digit.
  - Total count range is 0..MOD^DIGITS-1.

Decomposition:
- Shared package mod_n_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the function digit_width(MOD) = $clog2(MOD);
  - default constants MOD_DEF=5 and DIGITS_DEF=2.
- One sub-module, mod_down_digit, instantiated DIGITS times with a generate loop:
  - ports clk, rst, ld, ld_val[DW], dec, q[DW], borrow_out;
  - borrow_out = dec & (q==0), combinational;
  - the dec input of digit i+1 is borrow_out of digit i.
- Top level holds the FSM, load validation and the count==1 / count==0 detection.

Test Plan (MOD=5, DIGITS=2, count shown as digit1 digit0):
- Reset: assert rst 2 cycles -> count=00, busy=0, done=0, load_err=0.
- load 12 then start, pause=0 -> count sequence 12, 11, 10, 04, 03, 02, 01, 00; busy high for 7 cycles; done pulses once, in the cycle count first reads 00; then IDLE.
- Borrow/wrap: load 40, start, 6 decrements -> 34, 33, 32, 31, 30, 24; digit 0 wraps 0->4 while digit 1 decrements.
- Pause: load 03, start, pause high for 3 cycles after the first decrement -> count holds at 02 for those 3 cycles with busy=1; done arrives 3 cycles later than without pause.
- Zero/invalid/ignored inputs:
  - start with count=00 -> done one cycle later, busy never high;
  - load 15 (digit 0 = 5) -> load_err pulses, count unchanged;
  - load and start during RUN -> no effect.
- Reset mid-run: load 44, start, assert rst at count 41 -> next edge count=00, busy=0, no done pulse.
